// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM state encoding and the
// fetch-buffer entry layout used by the IF stage and its buffer.
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry fetch buffer. Entry 0 is always the head; a pop shifts entry 1
// down. Flush empties the buffer and overrides any push/pop in that cycle.
// Head outputs read as zero whenever the buffer is empty.
module if_fetch_fifo
    import cpu_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t push_entry_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;

    // Next-state of the two entries and the occupancy count.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = push_entry_i;
                    else                 ent1_d = push_entry_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind the survivor.
                    if (count_q == 2'd1) begin
                        ent0_d = push_entry_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer storage and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != 2'd0) ? ent0_q : '0;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, IDLE/RUN/FAULT control FSM, retired
// counter and a two-entry fetch buffer (if_fetch_fifo).
//
// Handshake: an entry transfers to ID in any cycle where if_valid && id_ready
// are both high at the rising clock edge; if_valid never depends on id_ready
// and the head entry stays stable until it transfers or a redirect flushes it.
//
// Optional feature: define IF_ALIGN_CHECK_EN to trap misaligned redirect
// targets in the FAULT state (exit only through resetn). Without it, FAULT
// is unreachable and fault is tied low.
//
// dbg_state exposes the FSM state for observation.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              resetn,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_inst,
    output logic [WORD_W-1:0] if_pc4,
    output logic              fault,
    output logic [WORD_W-1:0] retired_cnt,
    output fetch_state_e      dbg_state
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] retired_q, retired_d;

    logic              push, pop, flush;
    logic              buf_full;
    logic [1:0]        buf_count;
    fetch_entry_t      head;

    assign if_valid = (buf_count != 2'd0);
    assign buf_full = (buf_count == 2'(BUF_DEPTH));
    assign pop      = if_valid && id_ready && (state_q != FAULT);

    // FSM next-state, PC update and buffer push/flush control.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                // No fetch here; a redirect only retargets the PC.
                state_d = RUN;
                if (redirect) pc_d = redirect_pc;
            end
            RUN: begin
                if (redirect) begin
                    // This cycle's fetch belongs to the wrong path: drop it.
                    flush = 1'b1;
                    pc_d  = redirect_pc;
`ifdef IF_ALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) state_d = FAULT;
`endif
                end else if (!buf_full || pop) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end
            end
            FAULT: begin
                // Parked on the offending target until reset.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Retired count follows every transfer, including one coinciding with a flush.
    always_comb begin
        retired_d = retired_q + 32'(pop);
    end

    // State, PC and retired-count registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    if_fetch_fifo u_fifo (
        .clk_i        (clock),
        .rst_ni       (resetn),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (flush),
        .push_entry_i ('{pc: pc_q, inst: imem_rdata}),
        .count_o      (buf_count),
        .head_o       (head)
    );

    assign imem_addr   = pc_q;
    assign if_pc       = head.pc;
    assign if_inst     = head.inst;
    assign if_pc4      = if_valid ? (head.pc + 32'd4) : '0;
    assign retired_cnt = retired_q;
    assign dbg_state   = state_q;

`ifdef IF_ALIGN_CHECK_EN
    assign fault = (state_q == FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage. Each row holds the inputs
// for one cycle plus the outputs expected during that same cycle. Rows are
// applied at the falling edge: outputs are compared first, then the row's
// inputs are driven for the following rising edge.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc, if_inst, if_pc4;
    logic        fault;
    logic [31:0] retired_cnt;
    fetch_state_e dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        idr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic [31:0] eret;
        logic        ef;
    } vec_t;

    vec_t tbl[20];

    // clock / memory model
    always #5 clock = ~clock;
    assign imem_rdata = imem_addr ^ KEY;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_pc4      (if_pc4),
        .fault       (fault),
        .retired_cnt (retired_cnt),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_row(input string tag, input vec_t v);
        chk({tag, " if_valid"}, 32'(if_valid), 32'(v.ev));
        chk({tag, " if_pc"}, if_pc, v.ev ? v.epc : 32'h0);
        chk({tag, " if_inst"}, if_inst, v.ev ? (v.epc ^ KEY) : 32'h0);
        chk({tag, " if_pc4"}, if_pc4, v.ev ? (v.epc + 32'd4) : 32'h0);
        chk({tag, " imem_addr"}, imem_addr, v.eaddr);
        chk({tag, " retired_cnt"}, retired_cnt, v.eret);
        chk({tag, " fault"}, 32'(fault), 32'(v.ef));
        redirect    = v.redir;
        redirect_pc = v.rpc;
        id_ready    = v.idr;
        @(negedge clock);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " if_valid"}, 32'(if_valid), 32'h0);
        chk({tag, " if_pc"}, if_pc, 32'h0);
        chk({tag, " if_inst"}, if_inst, 32'h0);
        chk({tag, " if_pc4"}, if_pc4, 32'h0);
        chk({tag, " imem_addr"}, imem_addr, 32'h0);
        chk({tag, " retired_cnt"}, retired_cnt, 32'h0);
        chk({tag, " fault"}, 32'(fault), 32'h0);
        chk({tag, " state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // Assert reset between edges, check outputs at once, release on a falling edge.
    task automatic pulse_reset(input string tag);
        #2;
        resetn      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        #1;
        chk_zero(tag);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        // Main stream: fill, stall, redirect while full, redirect with pop, wrap.
        tbl[0]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         32'd0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         32'd0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4,         32'd0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h8,         32'd1, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'hC,         32'd2, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h10,        32'd2, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h10,        32'd2, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h10,        32'd2, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h10,        32'd2, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h10,        32'd2, 1'b0};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         32'h14,        32'd3, 1'b0};
        tbl[11] = '{1'b1, 32'h100,       1'b0, 1'b1, 32'hC,         32'h14,        32'd3, 1'b0};
        tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h100,       32'd3, 1'b0};
        tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       32'h104,       32'd3, 1'b0};
        tbl[14] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'h104,       32'h108,       32'd4, 1'b0};
        tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'hFFFF_FFF8, 32'd5, 1'b0};
        tbl[16] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd5, 1'b0};
        tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'd6, 1'b0};
        tbl[18] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h4,         32'd7, 1'b0};
        tbl[19] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8,         32'd7, 1'b0};

        // clock / reset block
        resetn      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        @(negedge clock);
        chk_zero("por");
        resetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_row($sformatf("tbl[%0d]", i), tbl[i]);
        end

        // Mid-stream reset with two entries buffered and retired_cnt = 7.
        pulse_reset("midrst");
        run_row("midrst c0", '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0});
        run_row("midrst c1", '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0});
        run_row("midrst c2", '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h4, 32'd0, 1'b0});

        // Stall from the first fetch: two entries held, no loss or duplication.
        pulse_reset("stall");
        run_row("stall c0", '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,  32'd0, 1'b0});
        run_row("stall c1", '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,  32'd0, 1'b0});
        run_row("stall c2", '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h4,  32'd0, 1'b0});
        for (int k = 3; k < 7; k++) begin
            run_row($sformatf("stall c%0d", k), '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h8, 32'd0, 1'b0});
        end
        run_row("stall c7", '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h8,  32'd0, 1'b0});
        run_row("stall c8", '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'hC,  32'd1, 1'b0});
        run_row("stall c9", '{1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'h10, 32'd2, 1'b0});

        // Redirect in IDLE, then a misaligned redirect in RUN (with a pop).
        pulse_reset("idle");
        run_row("idle c0", '{1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   32'h0,   32'd0, 1'b0});
        run_row("idle c1", '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h200, 32'd0, 1'b0});
        run_row("idle c2", '{1'b1, 32'h102, 1'b1, 1'b1, 32'h200, 32'h204, 32'd0, 1'b0});
`ifdef IF_ALIGN_CHECK_EN
        for (int k = 3; k < 7; k++) begin
            run_row($sformatf("align c%0d", k), '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h102, 32'd1, 1'b1});
        end
`else
        run_row("align c3", '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   32'h102, 32'd1, 1'b0});
        run_row("align c4", '{1'b0, 32'h0, 1'b1, 1'b1, 32'h102, 32'h106, 32'd1, 1'b0});
`endif

        // Reset is the only way out of FAULT; outputs clear immediately.
        pulse_reset("final");
        run_row("final c0", '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0});
        run_row("final c1", '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0});

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded at reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of fetch-buffer entries; only 2 is supported.
REQ-003 Port clock, input, 1, is the single pipeline clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1, is the asynchronous active-low reset.
REQ-005 Port imem_addr, output, 32, is the instruction memory byte address, equal to the PC register.
REQ-006 Port imem_rdata, input, 32, is the instruction word for imem_addr, valid within the same clock cycle.
REQ-007 Port redirect, input, 1, is a branch/jump taken from ID.
REQ-008 Port redirect_pc, input, 32, is the redirect target.
REQ-009 Port id_ready, input, 1, means ID accepts the head entry this cycle.
REQ-010 Port if_valid, output, 1, means if_pc, if_inst and if_pc4 hold a valid instruction.
REQ-011 Ports if_pc, if_inst and if_pc4 are 32-bit outputs carrying the head entry's PC, instruction word and PC+4.
REQ-012 Port fault, output, 1, is the misaligned-redirect fault flag.
REQ-013 Port retired_cnt, output, 32, counts entries accepted by ID.

Function
REQ-014 States are IDLE, RUN and FAULT; reset enters IDLE; IDLE moves to RUN unconditionally after one cycle, with no fetch in IDLE.
REQ-015 In RUN, a push of {pc, imem_rdata} occurs when (count < 2 or pop) and not redirect; on a push, pc <= pc + 4, wrapping modulo 2^32.
REQ-016 When no push occurs and there is no redirect, pc holds.
REQ-017 A pop occurs when if_valid and id_ready; on a pop the buffer advances FIFO order and retired_cnt increments, wrapping at 2^32.
REQ-018 Buffer full (count == 2) with no pop: no push, pc held, contents unchanged.
REQ-019 Push and pop in the same cycle when full: both occur and count stays 2.
REQ-020 Outputs are driven from buffer registers only, with no combinational path from imem_rdata; fetch-to-if_valid latency is 1 cycle.
REQ-021 Redirect in cycle N: buffer flushed (count <= 0), that cycle's fetch discarded, pc <= redirect_pc.
REQ-022 After redirect, the first target instruction is fetched in N+1 and appears on if_valid in N+2.
REQ-023 Redirect together with pop: flush wins, but the pop still counts in retired_cnt.
REQ-024 Redirect in IDLE: pc <= redirect_pc and the state still moves to RUN.
REQ-025 if_pc4 equals if_pc + 4, modulo 2^32.

Reset
REQ-026 resetn low asynchronously forces: pc = RESET_PC, count = 0, if_valid = 0, if_pc/if_inst/if_pc4 = 0, fault = 0, retired_cnt = 0, state = IDLE.
REQ-027 Reset asserted mid-operation discards all buffered entries; no entry is delivered after reset without a fresh fetch.

Configuration
REQ-028 With IF_ALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0] != 0 in RUN enters FAULT.
REQ-029 On entering FAULT: fault = 1, buffer flushed, pc holds the offending target, no further push or pop, and only reset exits.
REQ-030 Without IF_ALIGN_CHECK_EN, FAULT is unreachable, fault is tied 0, and redirect_pc is used as given.

Structure
REQ-031 Shared package cpu_pkg holds WORD_W = 32, the fetch-state enum {IDLE, RUN, FAULT} and the fetch-entry struct {pc, inst}.
REQ-032 The 2-entry buffer is sub-module if_fetch_fifo (push/pop/flush, count, head outputs); the FSM, PC and counter are in the top.

Verification
REQ-033 Reset release, RESET_PC = 0, id_ready = 1, memory word = address: if_valid rises in cycle 2, if_pc = 0, 4, 8, ... one per cycle.
REQ-034 id_ready = 0 for 5 cycles: exactly 2 entries buffered (pc 0, 4), imem_addr holds 8; on id_ready = 1, delivery is 0, 4, 8 with none lost or duplicated.
REQ-035 redirect = 1, redirect_pc = 0x100, while the buffer is full: next cycle if_valid = 0; the cycle after, if_pc = 0x100 and if_pc4 = 0x104.
REQ-036 PC = 0xFFFF_FFFC with id_ready = 1: next fetched pc = 0x0000_0000, and if_pc4 of that entry = 0.
REQ-037 With IF_ALIGN_CHECK_EN, redirect_pc = 0x102: fault = 1, if_valid = 0 and held until resetn low; without the macro, if_pc = 0x102 is delivered.
REQ-038 resetn pulsed low mid-stream with 2 entries buffered and retired_cnt = 7: all outputs are 0 immediately, and after release the first if_pc = RESET_PC.
